// File: rtl/l1i_mau.sv
// L1 instruction-cache memory access unit: turns one line-fill request into
// WORDS word reads on a pipelined memory port and returns the assembled line.
module l1i_mau #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WIDTH = 128,
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mau_req_val,
  input  logic [ADDR_WIDTH-1:0] mau_req_addr,
  output logic                  mau_req_ack,
  output logic [LINE_WIDTH-1:0] mau_ack_data,
  output logic                  mem_req_val,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_rdy,
  input  logic                  mem_rsp_val,
  input  logic [WORD_WIDTH-1:0] mem_rsp_data
);

  localparam int WORDS = LINE_WIDTH / WORD_WIDTH;
  localparam int CW    = $clog2(WORDS) + 1;
  localparam int WB_SH = $clog2(WORD_WIDTH / 8);

  typedef enum logic [1:0] {IDLE, FILL, ACK} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [CW-1:0]         iss_cnt_q, iss_cnt_d;
  logic [CW-1:0]         rsp_cnt_q, rsp_cnt_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic                  ack_q, ack_d;
  logic                  drop_q, drop_d;
  logic                  issue, capture, last;

  assign mem_req_val  = (state_q == FILL) && (iss_cnt_q < CW'(WORDS));
  assign mem_req_addr = mem_req_val ? base_q + (ADDR_WIDTH'(iss_cnt_q) << WB_SH) : '0;
  assign issue        = mem_req_val && mem_req_rdy;
  assign capture      = (state_q == FILL) && mem_rsp_val && (rsp_cnt_q < CW'(WORDS));
  assign last         = capture && (rsp_cnt_q == CW'(WORDS - 1));

  assign mau_req_ack  = ack_q;
  assign mau_ack_data = line_q;

  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    iss_cnt_d = iss_cnt_q;
    rsp_cnt_d = rsp_cnt_q;
    line_d    = line_q;
    drop_d    = drop_q;
    ack_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mau_req_val) begin
          base_d    = mau_req_addr & ~ADDR_WIDTH'(LINE_WIDTH / 8 - 1);
          iss_cnt_d = '0;
          rsp_cnt_d = '0;
          drop_d    = 1'b0;
          state_d   = FILL;
        end
      end
      FILL: begin
        if (issue) iss_cnt_d = iss_cnt_q + 1'b1;
        if (capture) rsp_cnt_d = rsp_cnt_q + 1'b1;
        for (int i = 0; i < WORDS; i++) begin
          if (capture && rsp_cnt_q == CW'(i)) line_d[i*WORD_WIDTH +: WORD_WIDTH] = mem_rsp_data;
        end
        // Once the requester lets go, the fill only drains outstanding reads.
        if (!mau_req_val) drop_d = 1'b1;
        if (last) begin
          state_d = ACK;
          ack_d   = mau_req_val && !drop_q;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      base_q    <= '0;
      iss_cnt_q <= '0;
      rsp_cnt_q <= '0;
      line_q    <= '0;
      ack_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      base_q    <= base_d;
      iss_cnt_q <= iss_cnt_d;
      rsp_cnt_q <= rsp_cnt_d;
      line_q    <= line_d;
      ack_q     <= ack_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_l1i_mau.sv
// Scoreboard bench for l1i_mau: directed fills with a pipelined memory model;
// expected request addresses and acks are queued at stimulus, checked by a monitor.
module tb_l1i_mau;

  logic         clk = 1'b0;
  logic         rst;
  logic         mau_req_val;
  logic [31:0]  mau_req_addr;
  logic         mau_req_ack;
  logic [127:0] mau_ack_data;
  logic         mem_req_val;
  logic [31:0]  mem_req_addr;
  logic         mem_req_rdy;
  logic         mem_rsp_val;
  logic [31:0]  mem_rsp_data;

  always #5 clk = ~clk;

  l1i_mau #(.ADDR_WIDTH(32), .LINE_WIDTH(128), .WORD_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .mau_req_val(mau_req_val), .mau_req_addr(mau_req_addr),
    .mau_req_ack(mau_req_ack), .mau_ack_data(mau_ack_data),
    .mem_req_val(mem_req_val), .mem_req_addr(mem_req_addr), .mem_req_rdy(mem_req_rdy),
    .mem_rsp_val(mem_rsp_val), .mem_rsp_data(mem_rsp_data)
  );

  typedef struct {
    logic [127:0] line;
    int           at;
  } ack_t;

  ack_t        exp_ack_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] rsp_data_q[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0;
  int pend = 0, beats_acc = 0, rsp_seen = 0;
  int stall_beat = -1, stall_len = 0, stalled = 0, rsp_from = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic flag(input string nm);
    n_vec++;
    n_err++;
    $display("FAIL %s: unexpected event (cycle %0d)", nm, cyc);
  endtask

  // Memory model: optional ready stall at one beat, responses in order one
  // cycle or more after acceptance, not before cycle rsp_from.
  initial begin
    mem_req_rdy  = 1'b1;
    mem_rsp_val  = 1'b0;
    mem_rsp_data = '0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        mem_rsp_val = 1'b0;
        mem_req_rdy = 1'b1;
        continue;
      end
      if (beats_acc == stall_beat && stalled < stall_len) begin
        mem_req_rdy = 1'b0;
        stalled++;
      end else begin
        mem_req_rdy = 1'b1;
      end
      if (pend > 0 && cyc >= rsp_from) begin
        mem_rsp_val  = 1'b1;
        mem_rsp_data = (rsp_data_q.size() > 0) ? rsp_data_q.pop_front() : 32'hDEAD_BEEF;
        pend--;
        rsp_seen++;
      end else begin
        mem_rsp_val = 1'b0;
      end
      if (mem_req_val && mem_req_rdy) begin
        pend++;
        beats_acc++;
      end
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    #2;
    if (mem_req_val) begin
      if (exp_addr_q.size() == 0) flag("mem_req_unexpected");
      else begin
        chk(mem_req_rdy ? "mem_req_addr" : "mem_req_addr_hold",
            128'(mem_req_addr), 128'(exp_addr_q[0]));
        if (mem_req_rdy) void'(exp_addr_q.pop_front());
      end
    end
    if (mau_req_ack) begin
      if (exp_ack_q.size() == 0) flag("ack_unexpected");
      else begin
        ack_t e;
        e = exp_ack_q.pop_front();
        chk("ack_data", mau_ack_data, e.line);
        chk("ack_cycle", 128'(cyc), 128'(e.at));
      end
    end
  end

  task automatic push_line(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                           input logic [31:0] d2, input logic [31:0] d3,
                           input bit exp_ack, input int at);
    ack_t e;
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(a + 32'(4 * i));
    rsp_data_q.push_back(d0);
    rsp_data_q.push_back(d1);
    rsp_data_q.push_back(d2);
    rsp_data_q.push_back(d3);
    if (exp_ack) begin
      e.line = {d3, d2, d1, d0};
      e.at   = at;
      exp_ack_q.push_back(e);
    end
  endtask

  task automatic start_fill(input logic [31:0] a, input logic [31:0] d0, input logic [31:0] d1,
                            input logic [31:0] d2, input logic [31:0] d3,
                            input bit exp_ack, input int lat, input int rsp_delay);
    int c0;
    @(negedge clk);
    #3;
    c0        = cyc;
    beats_acc = 0;
    stalled   = 0;
    rsp_seen  = 0;
    rsp_from  = c0 + rsp_delay;
    push_line(a, d0, d1, d2, d3, exp_ack, c0 + lat);
    mau_req_val  = 1'b1;
    mau_req_addr = a;
  endtask

  task automatic wait_ack_done();
    bit done = 0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      #3;
      if (exp_ack_q.size() == 0) done = 1;
    end
    if (!done) begin
      flag("ack_timeout");
      exp_ack_q.delete();
    end
    mau_req_val = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    bit seen;
    rst          = 1'b1;
    mau_req_val  = 1'b0;
    mau_req_addr = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ack", 128'(mau_req_ack), 128'(0));
    chk("rst_data", mau_ack_data, 128'(0));
    chk("rst_mem_val", 128'(mem_req_val), 128'(0));
    chk("rst_mem_addr", 128'(mem_req_addr), 128'(0));
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait fill
    start_fill(32'h0000_1230, 32'hA0, 32'hA1, 32'hA2, 32'hA3, 1, 6, 0);
    wait_ack_done();

    // Backpressure: three stalled cycles at the third beat
    stall_beat = 2;
    stall_len  = 3;
    start_fill(32'h0000_1230, 32'hB0, 32'hB1, 32'hB2, 32'hB3, 1, 9, 0);
    wait_ack_done();
    stall_beat = -1;

    // Responses held back until cycle 10
    start_fill(32'h0000_4560, 32'hC0, 32'hC1, 32'hC2, 32'hC3, 1, 14, 10);
    wait_ack_done();
    rsp_from = 0;

    // Abort after two responses: remaining reads drain, no ack
    start_fill(32'h0000_5000, 32'hD0, 32'hD1, 32'hD2, 32'hD3, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      #3;
      if (rsp_seen >= 2) seen = 1;
    end
    if (!seen) flag("abort_timeout");
    mau_req_val = 1'b0;
    repeat (8) @(negedge clk);
    chk("abort_reqs_drained", 128'(exp_addr_q.size()), 128'(0));
    chk("abort_rsps_drained", 128'(rsp_data_q.size()), 128'(0));
    chk("abort_pending", 128'(pend), 128'(0));
    start_fill(32'h0000_6010, 32'hE0, 32'hE1, 32'hE2, 32'hE3, 1, 6, 0);
    wait_ack_done();

    // Back-to-back: request held through ack with a new address
    start_fill(32'h0000_1100, 32'hF0, 32'hF1, 32'hF2, 32'hF3, 1, 6, 0);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      #3;
      if (mau_req_ack) seen = 1;
    end
    if (!seen) flag("b2b_first_ack_timeout");
    push_line(32'h0000_2000, 32'h1111_0000, 32'h2222_0001, 32'h3333_0002, 32'h4444_0003, 1, cyc + 7);
    mau_req_addr = 32'h0000_2000;
    wait_ack_done();

    // Reset in the middle of a fill
    start_fill(32'h0000_7000, 32'h77, 32'h78, 32'h79, 32'h7A, 0, 0, 0);
    seen = 0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      #3;
      if (beats_acc >= 2) seen = 1;
    end
    if (!seen) flag("midfill_timeout");
    rst = 1'b1;
    #1;
    chk("midrst_ack", 128'(mau_req_ack), 128'(0));
    chk("midrst_data", mau_ack_data, 128'(0));
    chk("midrst_mem_val", 128'(mem_req_val), 128'(0));
    chk("midrst_mem_addr", 128'(mem_req_addr), 128'(0));
    exp_addr_q.delete();
    rsp_data_q.delete();
    pend        = 0;
    mau_req_val = 1'b0;
    @(negedge clk);
    #3;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    start_fill(32'h0000_7020, 32'h9900_0000, 32'h9900_0001, 32'h9900_0002, 32'h9900_0003, 1, 6, 0);
    wait_ack_done();

    repeat (4) @(negedge clk);
    chk("end_reqs_left", 128'(exp_addr_q.size()), 128'(0));
    chk("end_acks_left", 128'(exp_ack_q.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
